ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It consumes the operands and destination register held by the ID/EX pipeline register. It stalls ID/EX and the upstream stages while computing, then presents a one-cycle result for capture into EX/MEM. It is the consuming end of the ID/EX interface for M-extension instructions; the single-cycle ALU handles all other operations.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- start_i  in  1  ID/EX holds a valid M-extension instruction.
- op_i  in  3  funct3 encoding:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_i  in  32  ID/EX read1_data (forwarded).
- rs2_i  in  32  ID/EX read2_data (forwarded).
- rd_i  in  5  ID/EX destination register.
- flush_i  in  1  kill the in-flight operation (branch/exception flush).
- stall_o  out  1  hold PC, IF/ID and ID/EX.
- done_o  out  1  result valid this cycle.
- result_o  out  32  operation result.
- rd_o  out  5  destination of the result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and flush_i=0 at a clock edge: latch op, rd and operand magnitudes, latch the result-sign fixup bits, clear count.
  - Special case detected (divisor==0, or signed DIV/REM with 0x80000000 / 0xFFFFFFFF): go to DONE with the result preloaded.
  - Otherwise go to CALC.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add over a 64-bit product of magnitudes.
  - Divide: restoring shift-subtract giving quotient and remainder.
  - count 0..31. At count==31 the next state is DONE and the sign fixup is applied into result_o.
- DONE: one cycle, then IDLE unconditionally. start_i is ignored in DONE, because ID/EX still shows the same instruction during that cycle.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Results:
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - DIV/DIVU return the quotient, truncated toward zero.
  - REM/REMU return the remainder; its sign follows the dividend.
- Divide by zero: quotient = 0xFFFFFFFF; remainder = rs1.
- Signed overflow: DIV gives 0x80000000; REM gives 0.
- stall_o = (IDLE & start_i & ~flush_i) | CALC. This is combinational, so ID/EX is held from the cycle the instruction arrives.
- done_o = DONE & ~flush_i.
- result_o and rd_o are registered. They hold their value after DONE until the next accepted start.
- flush_i:
  - In CALC: abort, next state IDLE, no done_o, result_o unchanged.
  - In IDLE: no accept.
  - In DONE: done_o suppressed.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, count=0, result_o=0, rd_o=0, done_o=0. stall_o then follows start_i.
- Reset asserted mid-CALC: immediate return to IDLE; the operation is lost with no done_o.
- Normal latency: start sampled at edge E0.
  - CALC covers the 32 cycles following E0..E31.
  - done_o is high in the cycle after edge E32.
  - stall_o is high from the arrival cycle through the last CALC cycle, then low in DONE, so EX/MEM captures result_o/rd_o at the edge ending DONE.
- Special-case latency: done_o is high in the cycle after E0; stall_o is high only in the arrival cycle.
- Back-to-back M instructions: the second instruction enters ID/EX at the edge ending DONE. It is accepted from IDLE one cycle later, giving a minimum of 1 idle-state cycle between operations.
- Operands are sampled only at accept; changes on rs1_i/rs2_i during CALC have no effect.

## Test plan
- **Signed multiply:** MUL 7 × 0xFFFFFFFD → result_o 0xFFFFFFEB; done_o 33 cycles after start; stall_o high for 33 cycles.
- **High-half multiply:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Signed divide:** DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; rd_o equals rd_i latched at accept.
- **Special cases, 1-cycle latency:**
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same overflow operands → 0.
- **Abort:** flush_i pulsed at CALC count 10 → IDLE next cycle, no done_o, result_o keeps its prior value; a following DIVU 100 / 7 → 14.
- **Reset and back-to-back:** rst low mid-CALC → all outputs 0, state IDLE; two consecutive MUL instructions → two done_o pulses 34 cycles apart, each accepted exactly once.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fixup applied as the last step completes.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [4:0]       rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o,
  output logic [4:0]       rd_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_res;
  logic        accept;

  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [31:0] hi_n, lo_n;
  logic [63:0] prod, prod_fix;
  logic [31:0] quo_fix, rem_fix, final_res;

  // Operand decode at accept: signedness, magnitudes and the early-out cases.
  always_comb begin
    a_signed    = op_i[2] ? ~op_i[0] : (op_i != 3'd3);
    b_signed    = op_i[2] ? ~op_i[0] : ~op_i[1];
    a_neg       = a_signed & rs1_i[31];
    b_neg       = b_signed & rs2_i[31];
    a_mag       = a_neg ? (32'd0 - rs1_i) : rs1_i;
    b_mag       = b_neg ? (32'd0 - rs2_i) : rs2_i;
    div_zero    = (rs2_i == 32'd0);
    div_ovf     = ~op_i[0] & (rs1_i == 32'h8000_0000) & (rs2_i == 32'hFFFF_FFFF);
    special     = op_i[2] & (div_zero | div_ovf);
    if (div_zero) special_res = op_i[1] ? rs1_i : 32'hFFFF_FFFF;
    else          special_res = op_i[1] ? 32'd0 : 32'h8000_0000;
    accept      = (state_q == S_IDLE) & start_i & ~flush_i;
  end

  // One iteration step; hi/lo hold product halves for multiply, remainder/quotient for divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    div_trial = {hi_q, lo_q[31]};
    div_diff  = {1'b0, div_trial} - {2'b00, b_q};
    div_ge    = ~div_diff[33];
    if (op_q[2]) begin
      hi_n = div_ge ? div_diff[31:0] : div_trial[31:0];
      lo_n = {lo_q[30:0], div_ge};
    end else begin
      hi_n = mul_sum[32:1];
      lo_n = {mul_sum[0], lo_q[31:1]};
    end
    prod     = {hi_n, lo_n};
    prod_fix = neg_q ? (64'd0 - prod) : prod;
    quo_fix  = neg_q ? (32'd0 - lo_n) : lo_n;
    rem_fix  = neg_q ? (32'd0 - hi_n) : hi_n;
    if (!op_q[2])     final_res = (op_q[1:0] == 2'd0) ? prod_fix[31:0] : prod_fix[63:32];
    else if (op_q[1]) final_res = rem_fix;
    else              final_res = quo_fix;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = op_i;
          rd_d    = rd_i;
          count_d = 5'd0;
          neg_d   = (op_i[2] & op_i[1]) ? a_neg : (a_neg ^ b_neg);
          hi_d    = 32'd0;
          lo_d    = op_i[2] ? a_mag : b_mag;
          b_d     = op_i[2] ? b_mag : a_mag;
          if (special) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
          count_d = 5'd0;
        end else begin
          hi_d    = hi_n;
          lo_d    = lo_n;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            result_d = final_res;
            state_d  = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      op_q     <= 3'd0;
      rd_q     <= 5'd0;
      neg_q    <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign stall_o  = accept | (state_q == S_CALC);
  assign done_o   = (state_q == S_DONE) & ~flush_i;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: results, latency, stall, flush, reset and back-to-back.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int passed = 0;
  int total  = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one instruction, hold it until done_o, scramble operands mid-CALC; lat=-1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int stalls);
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; flush_i = 1'b0;
    lat = -1; stalls = 0; res = 32'hDEAD_BEEF; rdo = 5'd0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (stall_o) stalls++;
      if (done_o) begin
        lat = c; res = result_o; rdo = rd_o;
        break;
      end
      @(negedge clk);
      if (c == 4) begin
        rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'd0;
      end
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; op_i = 3'd0; rs1_i = 32'd0; rs2_i = 32'd0;
    rd_i = 5'd0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (result_o !== 32'd0) $display("FAIL reset_result: got %h expected 00000000", result_o); else passed++;
    total++; if (rd_o !== 5'd0) $display("FAIL reset_rd: got %0d expected 0", rd_o); else passed++;
    total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_o); else passed++;
    total++; if (stall_o !== 1'b0) $display("FAIL reset_stall_idle: got %b expected 0", stall_o); else passed++;
    start_i = 1'b1; #1;
    total++; if (stall_o !== 1'b1) $display("FAIL reset_stall_follows_start: got %b expected 1", stall_o); else passed++;
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_mul();
    logic [31:0] res; logic [4:0] rdo; int lat, st;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, res, rdo, lat, st);
    $display("MUL 7 x fffffffd -> %h lat=%0d stall=%0d", res, lat, st);
    total++; if (res !== 32'hFFFF_FFEB) $display("FAIL mul_result: got %h expected ffffffeb", res); else passed++;
    total++; if (lat != 33) $display("FAIL mul_latency: got %0d expected 33", lat); else passed++;
    total++; if (st != 33) $display("FAIL mul_stall_cycles: got %0d expected 33", st); else passed++;
    total++; if (rdo !== 5'd3) $display("FAIL mul_rd: got %0d expected 3", rdo); else passed++;
  endtask

  task automatic test_mul_high();
    logic [31:0] res; logic [4:0] rdo; int lat, st;
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, res, rdo, lat, st);
    $display("MULH 80000000 x 80000000 -> %h lat=%0d", res, lat);
    total++; if (res !== 32'h4000_0000) $display("FAIL mulh_result: got %h expected 40000000", res); else passed++;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, res, rdo, lat, st);
    $display("MULHU ffffffff x ffffffff -> %h lat=%0d", res, lat);
    total++; if (res !== 32'hFFFF_FFFE) $display("FAIL mulhu_result: got %h expected fffffffe", res); else passed++;
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, res, rdo, lat, st);
    $display("MULHSU ffffffff x 2 -> %h lat=%0d", res, lat);
    total++; if (res !== 32'hFFFF_FFFF) $display("FAIL mulhsu_result: got %h expected ffffffff", res); else passed++;
  endtask

  task automatic test_div();
    logic [31:0] res; logic [4:0] rdo; int lat, st;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, res, rdo, lat, st);
    $display("DIV fffffff9 / 2 -> %h rd=%0d lat=%0d", res, rdo, lat);
    total++; if (res !== 32'hFFFF_FFFD) $display("FAIL div_result: got %h expected fffffffd", res); else passed++;
    total++; if (rdo !== 5'd10) $display("FAIL div_rd: got %0d expected 10", rdo); else passed++;
    total++; if (lat != 33) $display("FAIL div_latency: got %0d expected 33", lat); else passed++;
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, res, rdo, lat, st);
    $display("REM fffffff9 %% 2 -> %h rd=%0d lat=%0d", res, rdo, lat);
    total++; if (res !== 32'hFFFF_FFFF) $display("FAIL rem_result: got %h expected ffffffff", res); else passed++;
    total++; if (rdo !== 5'd11) $display("FAIL rem_rd: got %0d expected 11", rdo); else passed++;
  endtask

  task automatic test_special();
    logic [31:0] res; logic [4:0] rdo; int lat, st;
    run_op(3'd5, 32'd5, 32'd0, 5'd12, res, rdo, lat, st);
    $display("DIVU 5 / 0 -> %h lat=%0d stall=%0d", res, lat, st);
    total++; if (res !== 32'hFFFF_FFFF) $display("FAIL divu_zero_result: got %h expected ffffffff", res); else passed++;
    total++; if (lat != 1) $display("FAIL divu_zero_latency: got %0d expected 1", lat); else passed++;
    total++; if (st != 1) $display("FAIL divu_zero_stall: got %0d expected 1", st); else passed++;
    run_op(3'd7, 32'd5, 32'd0, 5'd13, res, rdo, lat, st);
    $display("REMU 5 / 0 -> %h lat=%0d", res, lat);
    total++; if (res !== 32'd5) $display("FAIL remu_zero_result: got %h expected 00000005", res); else passed++;
    total++; if (lat != 1) $display("FAIL remu_zero_latency: got %0d expected 1", lat); else passed++;
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, res, rdo, lat, st);
    $display("DIV 80000000 / ffffffff -> %h lat=%0d", res, lat);
    total++; if (res !== 32'h8000_0000) $display("FAIL div_ovf_result: got %h expected 80000000", res); else passed++;
    total++; if (lat != 1) $display("FAIL div_ovf_latency: got %0d expected 1", lat); else passed++;
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, res, rdo, lat, st);
    $display("REM 80000000 / ffffffff -> %h lat=%0d rd=%0d", res, lat, rdo);
    total++; if (res !== 32'd0) $display("FAIL rem_ovf_result: got %h expected 00000000", res); else passed++;
    total++; if (rdo !== 5'd15) $display("FAIL rem_ovf_rd: got %0d expected 15", rdo); else passed++;
  endtask

  task automatic test_abort();
    logic [31:0] res; logic [4:0] rdo; int lat, st, dones;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, res, rdo, lat, st);
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; rd_i = 5'd20;
    dones = 0;
    for (int c = 0; c < 11; c++) begin
      #1; if (done_o) dones++;
      @(negedge clk);
    end
    flush_i = 1'b1; start_i = 1'b0;
    #1; if (done_o) dones++;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    total++; if (stall_o !== 1'b0) $display("FAIL abort_idle_stall: got %b expected 0", stall_o); else passed++;
    for (int c = 0; c < 40; c++) begin
      #1; if (done_o) dones++;
      @(negedge clk);
    end
    $display("ABORT at count 10: dones=%0d result=%h", dones, result_o);
    total++; if (dones != 0) $display("FAIL abort_no_done: got %0d expected 0", dones); else passed++;
    total++; if (result_o !== 32'hFFFF_FFFE) $display("FAIL abort_result_kept: got %h expected fffffffe", result_o); else passed++;
    run_op(3'd5, 32'd100, 32'd7, 5'd21, res, rdo, lat, st);
    $display("DIVU 100 / 7 -> %h lat=%0d", res, lat);
    total++; if (res !== 32'd14) $display("FAIL abort_next_divu: got %h expected 0000000e", res); else passed++;
    total++; if (lat != 33) $display("FAIL abort_next_latency: got %0d expected 33", lat); else passed++;
  endtask

  task automatic test_reset_mid_calc();
    int dones;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd22;
    repeat (6) @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    #1;
    $display("RESET mid-CALC: result=%h rd=%0d done=%b stall=%b", result_o, rd_o, done_o, stall_o);
    total++; if (result_o !== 32'd0) $display("FAIL rstmid_result: got %h expected 00000000", result_o); else passed++;
    total++; if (rd_o !== 5'd0) $display("FAIL rstmid_rd: got %0d expected 0", rd_o); else passed++;
    total++; if (stall_o !== 1'b0) $display("FAIL rstmid_stall: got %b expected 0", stall_o); else passed++;
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      #1; if (done_o) dones++;
      @(negedge clk);
    end
    total++; if (dones != 0) $display("FAIL rstmid_no_done: got %0d expected 0", dones); else passed++;
  endtask

  task automatic test_back_to_back();
    int d1, d2, dones;
    logic [31:0] r1, r2; logic [4:0] q1, q2;
    d1 = -1; d2 = -1; dones = 0; r1 = 32'd0; r2 = 32'd0; q1 = 5'd0; q2 = 5'd0;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5; rd_i = 5'd7; flush_i = 1'b0;
    for (int c = 0; c < 120; c++) begin
      #1;
      if (done_o) begin
        dones++;
        if (d1 < 0) begin d1 = c; r1 = result_o; q1 = rd_o; end
        else if (d2 < 0) begin d2 = c; r2 = result_o; q2 = rd_o; end
      end
      @(negedge clk);
      if (c == d1) begin rs1_i = 32'd1000; rs2_i = 32'd1000; rd_i = 5'd9; end
      if (c == d2) start_i = 1'b0;
    end
    start_i = 1'b0;
    $display("BACK2BACK: done at %0d and %0d, results %h %h, rd %0d %0d, pulses=%0d", d1, d2, r1, r2, q1, q2, dones);
    total++; if (dones != 2) $display("FAIL b2b_pulses: got %0d expected 2", dones); else passed++;
    total++; if (d2 - d1 != 34) $display("FAIL b2b_spacing: got %0d expected 34", d2 - d1); else passed++;
    total++; if (r1 !== 32'd15) $display("FAIL b2b_result1: got %h expected 0000000f", r1); else passed++;
    total++; if (r2 !== 32'h000F_4240) $display("FAIL b2b_result2: got %h expected 000f4240", r2); else passed++;
    total++; if (q1 !== 5'd7) $display("FAIL b2b_rd1: got %0d expected 7", q1); else passed++;
    total++; if (q2 !== 5'd9) $display("FAIL b2b_rd2: got %0d expected 9", q2); else passed++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_abort();
    test_reset_mid_calc();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
